// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing the shared-memory datapath,
// with a mem_req/mem_ready handshake, optional memory timeout and illegal-opcode policy.
module riscv_mc_controller #(
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned MEM_TIMEOUT     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       sign,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic       halted,
    output logic       bus_error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch = 4'd0, StDecode = 4'd1, StMemAdr = 4'd2, StMemRead = 4'd3,
        StMemWb = 4'd4, StMemWrite = 4'd5, StExecR = 4'd6, StExecI = 4'd7,
        StAluWb = 4'd8, StBranch = 4'd9, StJal = 4'd10, StJalr = 4'd11,
        StLink = 4'd12, StLui = 4'd13, StAuipc = 4'd14, StHalt = 4'd15
    } state_t;

    localparam logic [6:0] OpLoad = 7'b0000011, OpStore = 7'b0100011, OpOp = 7'b0110011;
    localparam logic [6:0] OpImm = 7'b0010011, OpBranch = 7'b1100011, OpJal = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111, OpLui = 7'b0110111, OpAuipc = 7'b0010111;

    // Counter holds up to MEM_TIMEOUT; a 1-bit stub when the timeout is disabled.
    localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = (MEM_TIMEOUT == 0) ? '0 : CntW'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              bus_error_q;
    logic [CntW-1:0]   cnt_q;
    logic              req, wr, irw, pcw, rgw, tout;
    logic              instr_illegal, br_taken;
    logic [3:0]        exec_alu;

    // Decode-time legality check on the registered IR fields
    always_comb begin
        instr_illegal = 1'b0;
        case (opcode)
            OpOp: begin
                if (func7 == 7'b0100000) begin
                    instr_illegal = !(func3 == 3'b000 || func3 == 3'b101);
                end else if (func7 != 7'b0000000) begin
                    instr_illegal = 1'b1;
                end
            end
            OpImm: begin
                if (func3 == 3'b001) begin
                    instr_illegal = (func7 != 7'b0000000);
                end else if (func3 == 3'b101) begin
                    instr_illegal = (func7 != 7'b0000000) && (func7 != 7'b0100000);
                end
            end
            OpBranch: instr_illegal = (func3 == 3'b010) || (func3 == 3'b011);
            OpLoad, OpStore, OpJal, OpJalr, OpLui, OpAuipc: instr_illegal = 1'b0;
            default: instr_illegal = 1'b1;
        endcase
    end

    // Branch condition from ALU flags
    always_comb begin
        case (func3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = sign;
            3'b101:  br_taken = !sign;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // ALU operation for register/immediate arithmetic; SUB exists only in R-type
    always_comb begin
        case (func3)
            3'b000:  exec_alu = (opcode == OpOp && func7[5]) ? 4'd1 : 4'd0;
            3'b001:  exec_alu = 4'd7;
            3'b010:  exec_alu = 4'd5;
            3'b011:  exec_alu = 4'd6;
            3'b100:  exec_alu = 4'd4;
            3'b101:  exec_alu = func7[5] ? 4'd9 : 4'd8;
            3'b110:  exec_alu = 4'd3;
            default: exec_alu = 4'd2;
        endcase
    end

    // Next-state and Moore outputs; timeout overrides the normal successor
    always_comb begin
        state_d     = state_q;
        req         = 1'b0;
        wr          = 1'b0;
        adr_src     = 1'b0;
        irw         = 1'b0;
        pcw         = 1'b0;
        rgw         = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_control = 4'd0;
        imm_src     = 3'd0;
        result_src  = 2'd0;
        illegal     = 1'b0;
        tout        = 1'b0;
        case (state_q)
            StFetch: begin
                req        = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                if (mem_ready) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = (opcode == OpJal) ? 3'd4 : 3'd2;
                if (instr_illegal) begin
                    illegal = 1'b1;
                    state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
                end else begin
                    case (opcode)
                        OpLoad, OpStore: state_d = StMemAdr;
                        OpOp:            state_d = StExecR;
                        OpImm:           state_d = StExecI;
                        OpBranch:        state_d = StBranch;
                        OpJal:           state_d = StJal;
                        OpJalr:          state_d = StJalr;
                        OpLui:           state_d = StLui;
                        default:         state_d = StAuipc;
                    endcase
                end
            end
            StMemAdr: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (opcode == OpStore) ? 3'd1 : 3'd0;
                state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                req     = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = 2'd1;
                rgw        = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                req     = 1'b1;
                wr      = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExecR, StExecI: begin
                alu_src_a   = 2'd2;
                alu_src_b   = (state_q == StExecI) ? 2'd1 : 2'd0;
                alu_control = exec_alu;
                state_d     = StAluWb;
            end
            StAluWb: begin
                rgw     = 1'b1;
                state_d = StFetch;
            end
            StBranch: begin
                alu_src_a   = 2'd2;
                alu_control = 4'd1;
                pcw         = br_taken;
                state_d     = StFetch;
            end
            StJal: begin
                pcw       = 1'b1;
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                state_d   = StAluWb;
            end
            StJalr: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                pcw        = 1'b1;
                state_d    = StLink;
            end
            StLink: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                state_d   = StAluWb;
            end
            StLui, StAuipc: begin
                alu_src_a = (state_q == StLui) ? 2'd3 : 2'd1;
                alu_src_b = 2'd1;
                imm_src   = 3'd3;
                state_d   = StAluWb;
            end
            default: state_d = StHalt;
        endcase
        // A late mem_ready on the last allowed cycle still completes the access.
        if (MEM_TIMEOUT != 0 && req && !mem_ready && cnt_q == CntLast) begin
            tout    = 1'b1;
            state_d = StHalt;
        end
    end

    // State, sticky bus error and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFetch;
            bus_error_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_error_q <= bus_error_q | tout;
            if (req && mem_ready) begin
                cnt_q <= '0;
            end else if (MEM_TIMEOUT != 0 && req) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Strobes drop combinationally while reset is held, even mid-access
    assign mem_req   = req & ~rst;
    assign mem_write = wr & ~rst;
    assign ir_write  = irw & ~rst;
    assign pc_write  = pcw & ~rst;
    assign reg_write = rgw & ~rst;
    assign halted    = (state_q == StHalt);
    assign bus_error = bus_error_q;
    assign state     = state_q;

endmodule

// File: doc/riscv_mc_controller.md
# riscv_mc_controller

Multi-cycle control unit for the RV32I core: successor to the single-cycle controller, driving a datapath with registered IR, OldPC, A/B, ALUOut and memory-data registers over one shared instruction/data memory port. Moore FSM sequences each instruction over 3–5 cycles and stalls on a `mem_req`/`mem_ready` handshake. Parameters select the illegal-instruction policy and an optional memory timeout.

## Interface
- `HALT_ON_ILLEGAL`, 1: 1 = halt on illegal instruction; 0 = skip it as a NOP.
- `MEM_TIMEOUT`, 0: maximum wait cycles per memory access; 0 disables the timeout.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `opcode`, `func3`, `func7`  in  7/3/7  fields from the registered IR.
- `zero`, `sign`, `ltu`  in  1 each  ALU flags: result==0, signed rs1<rs2, unsigned rs1<rs2.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`, `mem_write`  out  1 each  memory access request; store.
- `adr_src`  out  1  memory address select: 0 PC, 1 ALUOut.
- `ir_write`, `pc_write`, `reg_write`  out  1 each  register write enables.
- `alu_src_a`  out  2  ALU A select: 0 PC, 1 OldPC, 2 A, 3 zero.
- `alu_src_b`  out  2  ALU B select: 0 B, 1 imm, 2 constant 4.
- `alu_control`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
- `imm_src`  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J.
- `result_src`  out  2  result select: 0 ALUOut, 1 mem data, 2 ALU result (combinational).
- `illegal`, `halted`, `bus_error`  out  1 each  status.
- `state`  out  4  current FSM state (debug).

## Operation
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9
  - JAL 10, JALR 11, LINK 12, LUI 13, AUIPC 14, HALT 15
- Unlisted outputs are 0 in each state.
- FETCH: `mem_req`=1, `adr_src`=0; ALU computes PC+4 (a=0, b=2, ADD, `result_src`=2). `ir_write` and `pc_write` are asserted only when `mem_ready`=1, and FETCH is held until then. Next state: DECODE.
- DECODE: ALU computes OldPC+immB (a=1, b=1, `imm_src`=2, ADD). Next state by opcode:
  - 0000011 load, 0100011 store → MEMADR.
  - 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH.
  - 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC.
  - Any other opcode is illegal.
- Also illegal:
  - R-type with `func7` other than 0000000, or 0100000 with `func3` 000/101.
  - Branch with `func3` 010/011.
  - Shift-immediate whose `func7` is not 0000000 (SLLI, SRLI) or 0100000 (SRAI).
- MEMADR: A+imm (`imm_src` I for load, S for store), ADD. Next: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: `mem_req`=1, `adr_src`=1; held until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=1, `reg_write`=1. Next: FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1; held until `mem_ready`, then FETCH.
- EXECR / EXECI: A op B, or A op immI. ALU op from `func3`:
  - 000 ADD; SUB only for R-type with `func7[5]`=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 SRL, or SRA when `func7[5]`=1.
  - 110 OR, 111 AND.
  - Next: ALUWB.
- ALUWB: `result_src`=0, `reg_write`=1. Next: FETCH.
- BRANCH: A−B (a=2, b=0, SUB), `result_src`=0. `pc_write` is asserted when the branch is taken:
  - beq `zero`, bne !`zero`
  - blt `sign`, bge !`sign`
  - bltu `ltu`, bgeu !`ltu`
  - Next: FETCH.
- JAL: `pc_write`=1 with `result_src`=0 (target computed in DECODE; `imm_src`=4 in DECODE when opcode is JAL); ALU computes OldPC+4. Next: ALUWB.
- JALR: ALU computes A+immI, `result_src`=2, `pc_write`=1 (the datapath clears bit 0). Next: LINK.
- LINK: OldPC+4. Next: ALUWB.
- LUI: a=3, b=1, `imm_src`=3, ADD. AUIPC: a=1, b=1, `imm_src`=3, ADD. Both go to ALUWB.
- Illegal instruction:
  - `illegal` pulses high for 1 cycle in DECODE.
  - `HALT_ON_ILLEGAL`=1: next state HALT. `HALT_ON_ILLEGAL`=0: next state FETCH, since the PC has already advanced.
- HALT: all strobes 0, `halted`=1. HALT is absorbing until reset.

## Timing
- Reset: `state`=FETCH; `halted`=0, `bus_error`=0, timeout counter 0. While `rst`=1, every strobe (`mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write`) is forced to 0.
- Cycle counts with zero-wait memory: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 4, JALR 5. Each wait cycle adds 1.
- `mem_ready` is ignored while `mem_req`=0. `mem_req` stays asserted, with address and `mem_write` stable, until the cycle in which `mem_ready`=1.
- Timeout (`MEM_TIMEOUT`=N>0):
  - The counter increments each cycle `mem_req`=1 and `mem_ready`=0, and clears on any handshake.
  - When the counter reaches N with `mem_ready` still 0, the next state is HALT and `bus_error` is set. `bus_error` is sticky until reset.
  - `mem_ready` arriving on the Nth cycle wins: the access completes and there is no error.
- Reset asserted mid-access: the FSM returns to FETCH immediately and all strobes drop in the same cycle.

## Test plan
- Reset, then ADD x3,x1,x2 (func7 0) with zero-wait memory → states 0,1,6,8; `alu_control`=0 in EXECR; `reg_write`=1 for exactly one cycle in ALUWB.
- LW with `mem_ready` low for 3 cycles on the data access → MEMREAD held 4 cycles with `adr_src`=1; `result_src`=1 and `reg_write`=1 in MEMWB.
- BEQ with `zero`=1, then `zero`=0; BLTU with `ltu`=1 → `pc_write`=1, 0, 1 respectively in BRANCH.
- JALR → `pc_write` in JALR with `result_src`=2; LINK outputs a=1, b=2; write-back in ALUWB; 5 cycles total.
- Opcode 0000000: with `HALT_ON_ILLEGAL`=1 → `illegal` pulse, then state 15 and `halted`=1 held. With 0 → `illegal` pulse, then FETCH.
- `MEM_TIMEOUT`=4 with `mem_ready` stuck low in FETCH → HALT with `bus_error`=1. Repeat with `mem_ready` arriving on the 4th cycle → normal DECODE.
